llc_cmd_sequencer: RTL and testbench

Command sequencer between a trace/command producer and the LLC block (CacheDesign). It buffers incoming {funct, address} commands in a small FIFO, issues them one at a time, and decodes each function code into the processor/snoop strobes and the snoop result. It holds each command stable until the cache's done handshake, and turns function 8 into a cache reset pulse. This replaces ad-hoc per-command sequencing in benches and lets any requester drive the LLC through a valid/ready interface.

---
 rtl/llc_cmd_sequencer_pkg.sv | 31 +++
 rtl/llc_cmd_sequencer_fifo.sv | 54 +++++
 rtl/llc_cmd_sequencer.sv | 162 ++++++++++++++++
 tb/tb_llc_cmd_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_cmd_sequencer_pkg.sv
// Shared LLC definitions: bus widths, trace function codes, sequencer states
// and the snoop result encoding.
package ParameterDefinitions;
    localparam int ADDRESS_SIZE  = 32;
    localparam int FUNCTION_SIZE = 4;

    localparam int unsigned FN_RD_DATA   = 0;
    localparam int unsigned FN_WR        = 1;
    localparam int unsigned FN_RD_INSTR  = 2;
    localparam int unsigned FN_SNP_UPGR  = 3;
    localparam int unsigned FN_SNP_RD    = 4;
    localparam int unsigned FN_SNP_RDX   = 5;
    localparam int unsigned FN_SNP_RWIM  = 6;
    localparam int unsigned FN_RESET     = 8;
    localparam int unsigned FN_PRINT     = 9;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        WAIT,
        CRST
    } seq_state_t;
endpackage

package GetSnoopResult;
    typedef enum logic [1:0] {
        HIT,
        HITM,
        NOHIT
    } snoop_result;
endpackage

// File: rtl/llc_cmd_sequencer_fifo.sv
// Synchronous command FIFO; a write while full is dropped even if a read
// happens in the same cycle.
module llc_cmd_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wrEn,
    input  logic [WIDTH-1:0]           wrData,
    input  logic                       rdEn,
    output logic [WIDTH-1:0]           rdData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             push;
    logic             pop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign push   = wrEn && !full;
    assign pop    = rdEn && !empty;
    assign rdData = mem[rdPtr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: rtl/llc_cmd_sequencer.sv
// Buffers {funct, address} trace commands and issues them one at a time to
// the LLC, holding each until done (or timeout); function 8 pulses cache_reset.
module llc_cmd_sequencer
    import GetSnoopResult::*;
#(
    parameter int ADDRESS_SIZE   = ParameterDefinitions::ADDRESS_SIZE,
    parameter int FUNCTION_SIZE  = ParameterDefinitions::FUNCTION_SIZE,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [FUNCTION_SIZE-1:0] cmd_funct,
    input  logic [ADDRESS_SIZE-1:0]  cmd_addr,
    input  logic                     done,
    output logic [FUNCTION_SIZE-1:0] funct,
    output logic [ADDRESS_SIZE-1:0]  Address,
    output logic                     PrRd,
    output logic                     PrWr,
    output logic                     BusRd_in,
    output logic                     BusRdX_in,
    output logic                     BusUpgr_in,
    output snoop_result              C_in,
    output logic                     cache_reset,
    output logic                     busy,
    output logic                     illegal_err,
    output logic                     timeout_err,
    output logic [31:0]              issued_count
);
    import ParameterDefinitions::*;

    localparam int CMD_W = ADDRESS_SIZE + FUNCTION_SIZE;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int WCW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    seq_state_t               state;
    logic [FUNCTION_SIZE-1:0] curFunct;
    logic [ADDRESS_SIZE-1:0]  curAddr;
    logic [WCW-1:0]           waitCount;
    logic [4:0]               strobeReg;

    logic [CMD_W-1:0]         fifoRdData;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic [CNT_W-1:0]         fifoCount;
    logic                     fifoPop;

    logic [4:0]               decStrobe;
    logic                     decIllegal;
    logic                     decReset;
    snoop_result              snoopNext;

    assign cmd_ready = !fifoFull;
    assign busy      = (state != IDLE) || (fifoCount != '0);
    assign fifoPop   = (state == IDLE) && !fifoEmpty;
    assign {PrRd, PrWr, BusUpgr_in, BusRd_in, BusRdX_in} = strobeReg;

    llc_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .wrEn   (cmd_valid),
        .wrData ({cmd_funct, cmd_addr}),
        .rdEn   (fifoPop),
        .rdData (fifoRdData),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifoCount)
    );

    // Strobe order: {PrRd, PrWr, BusUpgr_in, BusRd_in, BusRdX_in}.
    always_comb begin
        decStrobe  = '0;
        decIllegal = 1'b0;
        decReset   = 1'b0;
        case (32'(curFunct))
            FN_RD_DATA, FN_RD_INSTR: decStrobe = 5'b10000;
            FN_WR:                   decStrobe = 5'b01000;
            FN_SNP_UPGR:             decStrobe = 5'b00100;
            FN_SNP_RD:               decStrobe = 5'b00010;
            FN_SNP_RDX, FN_SNP_RWIM: decStrobe = 5'b00001;
            FN_RESET:                decReset  = 1'b1;
            FN_PRINT:                decStrobe = '0;
            default:                 decIllegal = 1'b1;
        endcase
    end

    always_comb begin
        case (curAddr[1:0])
            2'b00:   snoopNext = HIT;
            2'b01:   snoopNext = HITM;
            default: snoopNext = NOHIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            curFunct     <= '0;
            curAddr      <= '0;
            waitCount    <= '0;
            strobeReg    <= '0;
            cache_reset  <= 1'b0;
            illegal_err  <= 1'b0;
            timeout_err  <= 1'b0;
            issued_count <= '0;
            funct        <= FUNCTION_SIZE'(FN_PRINT);
            Address      <= '0;
            C_in         <= NOHIT;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifoEmpty) begin
                        {curFunct, curAddr} <= fifoRdData;
                        state               <= DECODE;
                    end
                end
                DECODE: begin
                    funct     <= curFunct;
                    Address   <= curAddr;
                    C_in      <= snoopNext;
                    waitCount <= '0;
                    if (decIllegal) begin
                        illegal_err  <= 1'b1;
                        issued_count <= issued_count + 32'd1;
                        state        <= IDLE;
                    end else if (decReset) begin
                        cache_reset <= 1'b1;
                        state       <= CRST;
                    end else begin
                        strobeReg <= decStrobe;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (done) begin
                        strobeReg    <= '0;
                        issued_count <= issued_count + 32'd1;
                        state        <= IDLE;
                    end else if (waitCount == WCW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err  <= 1'b1;
                        strobeReg    <= '0;
                        issued_count <= issued_count + 32'd1;
                        state        <= IDLE;
                    end else begin
                        waitCount <= waitCount + WCW'(1);
                    end
                end
                CRST: begin
                    cache_reset  <= 1'b0;
                    issued_count <= issued_count + 32'd1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_llc_cmd_sequencer.sv
// Directed plus randomized bench for llc_cmd_sequencer against a
// transaction-level model of command issue, strobes and counters.
module tb_llc_cmd_sequencer;
    import GetSnoopResult::*;

    localparam int TO    = 16;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_funct;
    logic [31:0] cmd_addr;
    logic        done;
    logic [3:0]  funct;
    logic [31:0] Address;
    logic        PrRd, PrWr, BusRd_in, BusRdX_in, BusUpgr_in;
    snoop_result C_in;
    logic        cache_reset;
    logic        busy;
    logic        illegal_err;
    logic        timeout_err;
    logic [31:0] issued_count;
    logic [4:0]  strobes;

    int          checks = 0;
    int          errors = 0;
    int unsigned modelIssued = 0;
    logic        modelIllegal = 1'b0;
    logic        modelTimeout = 1'b0;
    logic [35:0] pending [$];

    assign strobes = {PrRd, PrWr, BusUpgr_in, BusRd_in, BusRdX_in};

    always #5 clock = ~clock;

    llc_cmd_sequencer #(
        .ADDRESS_SIZE   (32),
        .FUNCTION_SIZE  (4),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_funct    (cmd_funct),
        .cmd_addr     (cmd_addr),
        .done         (done),
        .funct        (funct),
        .Address      (Address),
        .PrRd         (PrRd),
        .PrWr         (PrWr),
        .BusRd_in     (BusRd_in),
        .BusRdX_in    (BusRdX_in),
        .BusUpgr_in   (BusUpgr_in),
        .C_in         (C_in),
        .cache_reset  (cache_reset),
        .busy         (busy),
        .illegal_err  (illegal_err),
        .timeout_err  (timeout_err),
        .issued_count (issued_count)
    );

    // Expected strobe pattern {PrRd, PrWr, BusUpgr_in, BusRd_in, BusRdX_in}.
    function automatic logic [4:0] expStrobe(input logic [3:0] f);
        case (f)
            4'd0, 4'd2: return 5'b10000;
            4'd1:       return 5'b01000;
            4'd3:       return 5'b00100;
            4'd4:       return 5'b00010;
            4'd5, 4'd6: return 5'b00001;
            default:    return 5'b00000;
        endcase
    endfunction

    function automatic snoop_result expSnoop(input logic [31:0] a);
        if (a[1:0] == 2'b00) return HIT;
        if (a[1:0] == 2'b01) return HITM;
        return NOHIT;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkCounters();
        check("issued_count", issued_count, modelIssued);
        check("illegal_err", illegal_err, modelIllegal);
        check("timeout_err", timeout_err, modelTimeout);
    endtask

    // One command from an idle, empty sequencer; d = cycles after the strobe
    // appears before done is raised (d >= TO means the command times out).
    task automatic runSingle(input logic [3:0] f, input logic [31:0] a, input int d);
        logic [4:0] es;
        bit         ill;
        bit         rst;
        bit         tmo;
        int         high;
        es  = expStrobe(f);
        ill = (f == 4'd7) || (f > 4'd9);
        rst = (f == 4'd8);
        @(negedge clock);
        check("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_funct = f;
        cmd_addr  = a;
        done      = 1'($urandom_range(0, 1));
        @(negedge clock);
        cmd_valid = 1'b0;
        check("busy_after_push", busy, 1);
        check("no_strobe_early", strobes, 0);
        done = 1'($urandom_range(0, 1));
        @(negedge clock);
        check("no_strobe_decode", strobes, 0);
        check("no_crst_decode", cache_reset, 0);
        done = 1'($urandom_range(0, 1));
        @(negedge clock);
        done = 1'b0;
        check("funct_out", funct, f);
        check("addr_out", Address, a);
        check("c_in", C_in, expSnoop(a));
        if (ill) begin
            modelIssued++;
            modelIllegal = 1'b1;
            check("illegal_no_strobe", strobes, 0);
            check("illegal_no_crst", cache_reset, 0);
            check("illegal_idle", busy, 0);
        end else if (rst) begin
            check("crst_high", cache_reset, 1);
            check("crst_no_strobe", strobes, 0);
            @(negedge clock);
            modelIssued++;
            check("crst_one_cycle", cache_reset, 0);
            check("crst_idle", busy, 0);
        end else begin
            tmo  = (d >= TO);
            high = tmo ? TO : d + 1;
            for (int i = 0; i < high; i++) begin
                check("strobe_hold", strobes, es);
                check("funct_hold", funct, f);
                check("addr_hold", Address, a);
                if (i == d) done = 1'b1;
                @(negedge clock);
                done = 1'b0;
            end
            modelIssued++;
            if (tmo) modelTimeout = 1'b1;
            check("strobe_drop", strobes, 0);
            check("idle_after_cmd", busy, 0);
        end
        checkCounters();
    endtask

    // Wait (bounded) for the next queued command to appear and retire it with done.
    task automatic drainOne(input bit lastOne);
        logic [35:0] c;
        bit          seen;
        c    = pending.pop_front();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (strobes != 0) seen = 1'b1;
            else @(negedge clock);
        end
        check("drain_strobe_seen", seen, 1);
        check("drain_strobe", strobes, expStrobe(c[35:32]));
        check("drain_funct", funct, c[35:32]);
        check("drain_addr", Address, c[31:0]);
        check("drain_c_in", C_in, expSnoop(c[31:0]));
        done = 1'b1;
        @(negedge clock);
        done = 1'b0;
        modelIssued++;
        check("drain_drop", strobes, 0);
        check("drain_issued", issued_count, modelIssued);
        if (lastOne) check("drain_idle", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  f;
        logic [31:0] a;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_funct = '0;
        cmd_addr  = '0;
        done      = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_strobes", strobes, 0);
        check("rst_funct", funct, 9);
        check("rst_addr", Address, 0);
        check("rst_c_in", C_in, NOHIT);
        check("rst_crst", cache_reset, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        checkCounters();
        reset = 1'b0;

        runSingle(4'd0, 32'h1000, 4);
        runSingle(4'd5, 32'h2001, 1);
        runSingle(4'd1, 32'h3003, 0);
        runSingle(4'd2, 32'h4002, 2);
        runSingle(4'd3, 32'h5000, 3);
        runSingle(4'd9, 32'h6001, 2);
        runSingle(4'd8, 32'h0, 0);
        runSingle(4'd7, 32'h0, 0);
        runSingle(4'd6, 32'h7005, TO - 1);
        runSingle(4'd4, 32'h10, TO + 4);

        // Fill the FIFO while a write waits in WAIT.
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_funct = 4'd1;
        cmd_addr  = 32'h8000;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("full_first_strobe", strobes, 5'b01000);
        for (int k = 0; k < DEPTH + 1; k++) begin
            f = 4'($urandom_range(0, 6));
            a = $urandom;
            pending.push_back({f, a});
            cmd_valid = 1'b1;
            cmd_funct = f;
            cmd_addr  = a;
            if (k < DEPTH) begin
                check("ready_not_full", cmd_ready, 1);
                @(negedge clock);
            end
        end
        check("ready_full", cmd_ready, 0);
        @(negedge clock);
        check("ready_full_hold", cmd_ready, 0);
        check("first_still_waiting", strobes, 5'b01000);
        done = 1'b1;
        @(negedge clock);
        done = 1'b0;
        modelIssued++;
        check("first_done_drop", strobes, 0);
        check("ready_full_at_pop", cmd_ready, 0);
        @(negedge clock);
        check("ready_after_pop", cmd_ready, 1);
        @(negedge clock);
        cmd_valid = 1'b0;
        while (pending.size() > 0) drainOne(pending.size() == 1);
        checkCounters();

        for (int n = 0; n < 40; n++) begin
            runSingle(4'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, TO + 1)));
        end

        // Reset in the middle of WAIT with two commands queued.
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_funct = 4'd4;
        cmd_addr  = 32'h20;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("pre_reset_strobe", strobes, 5'b00010);
        for (int k = 0; k < 2; k++) begin
            cmd_valid = 1'b1;
            cmd_funct = 4'd0;
            cmd_addr  = $urandom;
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        modelIssued  = 0;
        modelIllegal = 1'b0;
        modelTimeout = 1'b0;
        check("mid_rst_strobes", strobes, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_funct", funct, 9);
        check("mid_rst_c_in", C_in, NOHIT);
        checkCounters();
        repeat (4) @(negedge clock);
        check("post_rst_quiet", strobes, 0);
        check("post_rst_busy", busy, 0);
        runSingle(4'd2, 32'h9001, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
